// File: rtl/countdown_timer_bcd.sv
// Minutes:seconds BCD countdown timer with start/pause, set buttons and a timed alarm.
// Digits and state are registered; running/alarm decode the state register.
module countdown_timer_bcd #(
  parameter int unsigned ALARM_SECS = 5,
  parameter int unsigned MAX_MIN    = 59
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_set_min,
  input  logic       btn_set_sec,
  input  logic       btn_clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned CntW     = $clog2(ALARM_SECS + 1);
  localparam logic [3:0]  MaxMin10 = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MaxMin1  = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

  state_e            state_q, state_d;
  logic [3:0]        min10_q, min10_d, min1_q, min1_d, sec10_q, sec10_d, sec1_q, sec1_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]        dec_min10, dec_min1, dec_sec10, dec_sec1;
  logic              is_zero, dec_zero;

  assign is_zero = (min10_q == 4'd0) && (min1_q == 4'd0) && (sec10_q == 4'd0) && (sec1_q == 4'd0);
  assign cnt_inc = cnt_q + CntW'(1);

  // One-second BCD decrement with borrow through all four digits.
  always_comb begin
    dec_min10 = min10_q;
    dec_min1  = min1_q;
    dec_sec10 = sec10_q;
    dec_sec1  = sec1_q;
    if (sec1_q != 4'd0) begin
      dec_sec1 = sec1_q - 4'd1;
    end else if (sec10_q != 4'd0) begin
      dec_sec10 = sec10_q - 4'd1;
      dec_sec1  = 4'd9;
    end else if ((min10_q != 4'd0) || (min1_q != 4'd0)) begin
      dec_sec10 = 4'd5;
      dec_sec1  = 4'd9;
      if (min1_q != 4'd0) begin
        dec_min1 = min1_q - 4'd1;
      end else begin
        dec_min1  = 4'd9;
        dec_min10 = min10_q - 4'd1;
      end
    end
  end

  assign dec_zero = (dec_min10 == 4'd0) && (dec_min1 == 4'd0) &&
                    (dec_sec10 == 4'd0) && (dec_sec1 == 4'd0);

  always_comb begin
    state_d = state_q;
    min10_d = min10_q;
    min1_d  = min1_q;
    sec10_d = sec10_q;
    sec1_d  = sec1_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (btn_clear) begin
          {min10_d, min1_d, sec10_d, sec1_d} = 16'h0000;
        end else if (btn_start && !is_zero) begin
          state_d = StRun;
        end else begin
          // A start press at 00:00 is ignored, so set buttons still apply.
          if (btn_set_sec) begin
            if (sec10_q == 4'd5 && sec1_q == 4'd9) begin
              sec10_d = 4'd0;
              sec1_d  = 4'd0;
            end else if (sec1_q == 4'd9) begin
              sec10_d = sec10_q + 4'd1;
              sec1_d  = 4'd0;
            end else begin
              sec1_d = sec1_q + 4'd1;
            end
          end
          if (btn_set_min) begin
            if (min10_q == MaxMin10 && min1_q == MaxMin1) begin
              min10_d = 4'd0;
              min1_d  = 4'd0;
            end else if (min1_q == 4'd9) begin
              min10_d = min10_q + 4'd1;
              min1_d  = 4'd0;
            end else begin
              min1_d = min1_q + 4'd1;
            end
          end
        end
      end
      StRun: begin
        if (btn_clear) begin
          state_d = StIdle;
          {min10_d, min1_d, sec10_d, sec1_d} = 16'h0000;
        end else if (btn_start) begin
          state_d = StPause;
        end else if (clk_sec) begin
          {min10_d, min1_d, sec10_d, sec1_d} = {dec_min10, dec_min1, dec_sec10, dec_sec1};
          if (dec_zero) begin
            state_d = StAlarm;
            cnt_d   = '0;
          end
        end
      end
      StPause: begin
        if (btn_clear) begin
          state_d = StIdle;
          {min10_d, min1_d, sec10_d, sec1_d} = 16'h0000;
        end else if (btn_start) begin
          state_d = StRun;
        end
      end
      StAlarm: begin
        if (btn_clear || btn_start) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (clk_sec) begin
          if (cnt_inc == CntW'(ALARM_SECS)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= StIdle;
      min10_q <= 4'd0;
      min1_q  <= 4'd0;
      sec10_q <= 4'd0;
      sec1_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min10_q <= min10_d;
      min1_q  <= min1_d;
      sec10_q <= sec10_d;
      sec1_q  <= sec1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign min10   = min10_q;
  assign min1    = min1_q;
  assign sec10   = sec10_q;
  assign sec1    = sec1_q;
  assign running = (state_q == StRun);
  assign alarm   = (state_q == StAlarm);

endmodule
